// File: rtl/sr_event_recorder.sv
// Clocked SR latch model with a timestamped transition log.
// Every change of {Q,QN} is pushed into a FIFO that a consumer drains over valid/ready.
module sr_event_recorder #(
  parameter int unsigned TSW   = 16,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     S,
  input  logic                     R,
  input  logic                     CLR,
  output logic                     Q,
  output logic                     QN,
  output logic                     INV,
  output logic                     EV_VALID,
  input  logic                     EV_READY,
  output logic [TSW+2:0]           EV_DATA,
  output logic                     OVF,
  output logic [$clog2(DEPTH):0]   COUNT
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned DW = TSW + 3;

  logic          s_meta_q, s_meta_d, s_sync_q, s_sync_d;
  logic          r_meta_q, r_meta_d, r_sync_q, r_sync_d;
  logic          q_q, q_d, qn_q, qn_d, inv_q, inv_d;
  logic [TSW-1:0] ts_q, ts_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;
  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] mem_d [DEPTH];

  logic push_c, pop_c, full_c, accept_c, drop_c;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      s_meta_q <= 1'b0;
      s_sync_q <= 1'b0;
      r_meta_q <= 1'b0;
      r_sync_q <= 1'b0;
      q_q      <= 1'b0;
      qn_q     <= 1'b1;
      inv_q    <= 1'b0;
      ts_q     <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else begin
      s_meta_q <= s_meta_d;
      s_sync_q <= s_sync_d;
      r_meta_q <= r_meta_d;
      r_sync_q <= r_sync_d;
      q_q      <= q_d;
      qn_q     <= qn_d;
      inv_q    <= inv_d;
      ts_q     <= ts_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= mem_d[i];
    end
  end

  always_comb begin
    s_meta_d = S;
    s_sync_d = s_meta_q;
    r_meta_d = R;
    r_sync_d = r_meta_q;
    q_d      = q_q;
    qn_d     = qn_q;
    inv_d    = 1'b0;
    ts_d     = ts_q + TSW'(1);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    for (int i = 0; i < int'(DEPTH); i++) mem_d[i] = mem_q[i];

    // Leaving the invalid state resolves deterministically to reset.
    unique case ({s_sync_q, r_sync_q})
      2'b10: begin q_d = 1'b1; qn_d = 1'b0; end
      2'b01: begin q_d = 1'b0; qn_d = 1'b1; end
      2'b11: begin q_d = 1'b0; qn_d = 1'b0; inv_d = 1'b1; end
      default: begin
        if (inv_q) begin
          q_d  = 1'b0;
          qn_d = 1'b1;
        end
      end
    endcase

    push_c   = {q_d, qn_d} != {q_q, qn_q};
    pop_c    = (count_q != '0) && EV_READY;
    full_c   = count_q == CW'(DEPTH);
    accept_c = push_c && (!full_c || pop_c);
    drop_c   = push_c && full_c && !pop_c;

    if (accept_c) begin
      mem_d[wr_ptr_q] = {ts_q, inv_d, q_d, qn_d};
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop_c) rd_ptr_d = rd_ptr_q + AW'(1);

    count_d = count_q + CW'(accept_c) - CW'(pop_c);
    ovf_d   = (ovf_q && !CLR) || drop_c;
  end

  assign Q        = q_q;
  assign QN       = qn_q;
  assign INV      = inv_q;
  assign EV_VALID = count_q != '0;
  assign EV_DATA  = mem_q[rd_ptr_q];
  assign OVF      = ovf_q;
  assign COUNT    = count_q;

endmodule

// File: tb/tb_sr_event_recorder.sv
// Randomised bench for sr_event_recorder against a behavioural event-log model.
// Two instances share stimulus: TSW=16 and TSW=4 (timestamp wrap).
module tb_sr_event_recorder;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned TSW   = 16;
  localparam int unsigned TSW4  = 4;
  localparam int unsigned CW    = $clog2(DEPTH) + 1;

  logic CLK = 1'b0;
  logic RST = 1'b0;
  logic S = 1'b0, R = 1'b0, CLR = 1'b0, EV_READY = 1'b0;

  logic q, qn, inv, ev_valid, ovf;
  logic [TSW+2:0] ev_data;
  logic [CW-1:0]  count;
  logic q4, qn4, inv4, ev_valid4, ovf4;
  logic [TSW4+2:0] ev_data4;
  logic [CW-1:0]   count4;

  sr_event_recorder #(.TSW(TSW), .DEPTH(DEPTH)) u_dut (
    .CLK(CLK), .RST(RST), .S(S), .R(R), .CLR(CLR),
    .Q(q), .QN(qn), .INV(inv), .EV_VALID(ev_valid), .EV_READY(EV_READY),
    .EV_DATA(ev_data), .OVF(ovf), .COUNT(count)
  );

  sr_event_recorder #(.TSW(TSW4), .DEPTH(DEPTH)) u_dut4 (
    .CLK(CLK), .RST(RST), .S(S), .R(R), .CLR(CLR),
    .Q(q4), .QN(qn4), .INV(inv4), .EV_VALID(ev_valid4), .EV_READY(EV_READY),
    .EV_DATA(ev_data4), .OVF(ovf4), .COUNT(count4)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int unsigned ts;
    bit inv, q, qn;
  } ev_t;

  // Model: latch as an abstract state (0 = reset, 1 = set, 2 = invalid) plus an event queue.
  ev_t         fq[$];
  int          st;
  bit          s_d1, s_d2, r_d1, r_d2;
  bit          m_ovf;
  int unsigned m_ts;
  int          n_checks = 0;
  int          n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  task automatic model_reset();
    fq.delete();
    st    = 0;
    s_d1  = 0; s_d2 = 0; r_d1 = 0; r_d2 = 0;
    m_ovf = 0;
    m_ts  = 0;
  endtask

  task automatic model_edge();
    bit ss, rr, pop, hit;
    int nst;
    ev_t e;
    ss = s_d2; rr = r_d2;
    s_d2 = s_d1; s_d1 = S;
    r_d2 = r_d1; r_d1 = R;
    if (ss && rr)  nst = 2;
    else if (ss)   nst = 1;
    else if (rr)   nst = 0;
    else           nst = (st == 2) ? 0 : st;
    pop = (fq.size() > 0) && EV_READY;
    hit = 0;
    if (nst != st) begin
      e.ts = m_ts; e.inv = (nst == 2); e.q = (nst == 1); e.qn = (nst == 0);
      if (fq.size() == DEPTH && !pop) hit = 1;
      else begin
        if (pop) void'(fq.pop_front());
        pop = 0;
        fq.push_back(e);
      end
    end
    if (pop) void'(fq.pop_front());
    m_ovf = (m_ovf && !CLR) || hit;
    m_ts++;
    st = nst;
  endtask

  task automatic check_all();
    logic [TSW+2:0]  exp16;
    logic [TSW4+2:0] exp4;
    chk("q",     32'(q),        32'(st == 1));
    chk("qn",    32'(qn),       32'(st == 0));
    chk("inv",   32'(inv),      32'(st == 2));
    chk("count", 32'(count),    32'(fq.size()));
    chk("valid", 32'(ev_valid), 32'(fq.size() != 0));
    chk("ovf",   32'(ovf),      32'(m_ovf));
    chk("q4",     32'(q4),        32'(st == 1));
    chk("qn4",    32'(qn4),       32'(st == 0));
    chk("inv4",   32'(inv4),      32'(st == 2));
    chk("count4", 32'(count4),    32'(fq.size()));
    chk("valid4", 32'(ev_valid4), 32'(fq.size() != 0));
    chk("ovf4",   32'(ovf4),      32'(m_ovf));
    if (fq.size() != 0) begin
      exp16 = {TSW'(fq[0].ts), fq[0].inv, fq[0].q, fq[0].qn};
      exp4  = {TSW4'(fq[0].ts), fq[0].inv, fq[0].q, fq[0].qn};
      chk("data",  32'(ev_data),  32'(exp16));
      chk("data4", 32'(ev_data4), 32'(exp4));
    end
  endtask

  task automatic step();
    @(posedge CLK);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must clear before the next edge.
  task automatic mid_reset();
    #2 RST = 1'b1;
    #1;
    model_reset();
    check_all();
    chk("rst_data",  32'(ev_data),  32'd0);
    chk("rst_data4", 32'(ev_data4), 32'd0);
    S = 0; R = 0;
    @(negedge CLK);
    RST = 1'b0;
  endtask

  initial begin
    int inv_cnt;
    int hold;
    model_reset();
    #2 RST = 1'b1;
    #10;
    check_all();
    chk("rst_data", 32'(ev_data), 32'd0);
    @(negedge CLK);
    RST = 1'b0;

    // Set pulse, then reset.
    run(4);
    S = 1; run(5); S = 0; run(4);
    R = 1; run(3); R = 0; run(3);
    EV_READY = 1; run(4); EV_READY = 0;

    // Invalid state held for four synchronised cycles.
    inv_cnt = 0;
    S = 1; R = 1;
    for (int i = 0; i < 10; i++) begin
      if (i == 4) begin S = 0; R = 0; end
      step();
      if (inv) inv_cnt++;
    end
    chk("inv_len", 32'(inv_cnt), 32'd4);
    EV_READY = 1; run(4); EV_READY = 0;

    // Ten transitions into an unread FIFO: two dropped.
    for (int i = 0; i < 10; i++) begin
      S = (i % 2 == 0); R = !S; run(3);
    end
    S = 0; R = 0; run(3);
    chk("full_count", 32'(count), 32'(DEPTH));
    chk("ovf_set", 32'(ovf), 32'd1);
    EV_READY = 1; run(10); EV_READY = 0;
    chk("drained", 32'(count), 32'd0);
    CLR = 1; run(1); CLR = 0;
    chk("ovf_clr", 32'(ovf), 32'd0);

    // Full FIFO with a pop on the same edge as a push.
    for (int i = 0; i < 8; i++) begin
      S = (i % 2 == 0); R = !S; run(3);
    end
    S = 0; R = 0;
    chk("refill", 32'(count), 32'(DEPTH));
    S = 1; run(2); EV_READY = 1; run(1); EV_READY = 0;
    chk("pushpop_count", 32'(count), 32'(DEPTH));
    chk("pushpop_ovf", 32'(ovf), 32'd0);
    S = 0; run(2);
    EV_READY = 1; run(10); EV_READY = 0;

    // Timestamp wrap on the narrow instance, then reset with queued events.
    mid_reset();
    run(20);
    S = 1; run(4); S = 0;
    R = 1; run(3); R = 0;
    S = 1; run(3); S = 0; run(2);
    chk("queued3", 32'(count), 32'd3);
    mid_reset();
    run(3);

    // Random levels, handshake and clears, with occasional resets.
    for (int b = 0; b < 400; b++) begin
      S        = ($urandom % 3) == 0;
      R        = ($urandom % 3) == 0;
      EV_READY = ($urandom % 3) != 0 && (b % 50) > 15;
      CLR      = ($urandom % 12) == 0;
      hold     = $urandom_range(1, 6);
      run(hold);
      if (($urandom % 60) == 0) mid_reset();
    end
    S = 0; R = 0; CLR = 0; EV_READY = 1;
    run(12);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
